// File: rtl/imem_responder.sv
// imem_responder: memory-side responder for the icache refill interface.
// Accepts one word read at a time on mem_read/mem_addr and answers after
// LATENCY cycles with a one-cycle mem_ready pulse and mem_data. Misaligned
// requests return a NOP word together with a mem_err pulse. A write-only
// load port preloads the backing array in any state.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset (array contents are kept)
//   mem_read   read request, sampled only while idle
//   mem_addr   byte address of the requested word
//   mem_ready  one-cycle pulse, mem_data valid
//   mem_data   returned word, holds its value outside the response cycle
//   mem_err    pulse with mem_ready when the request was misaligned
//   busy       high while a request is outstanding
//   load_en    program-load write strobe
//   load_addr  byte address for the load write (low two bits dropped)
//   load_data  word to write
//
// LATENCY must lie in 1..15.
module imem_responder #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic [XLEN-1:0] mem_addr,
    output logic            mem_ready,
    output logic [XLEN-1:0] mem_data,
    output logic            mem_err,
    output logic            busy,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_addr,
    input  logic [XLEN-1:0] load_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013);

    logic [XLEN-1:0]  mem_q [DEPTH_WORDS];

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             mis_q,   mis_d;
    logic             ready_q, ready_d;
    logic             err_q,   err_d;
    logic             busy_q,  busy_d;
    logic [XLEN-1:0]  data_q,  data_d;

    // Address bits outside the word index are intentionally ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[XLEN-1:IDX_W+2],
                                load_addr[XLEN-1:IDX_W+2], load_addr[1:0]};

    // Request sequencing and response generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_read) begin
                    idx_d   = mem_addr[IDX_W+1:2];
                    mis_d   = (mem_addr[1:0] != 2'b00);
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Leave on the edge where the count reaches zero.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Array is read on the edge entering RESP; the nonblocking array write
        // in the same edge is not yet visible, giving read-before-write.
        if (state_d == ST_RESP) begin
            data_d = mis_d ? NOP_WORD : mem_q[idx_d];
        end

        ready_d = (state_d == ST_RESP);
        err_d   = (state_d == ST_RESP) && mis_d;
        busy_d  = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    // Program-load write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && load_en) begin
            mem_q[load_addr[IDX_W+1:2]] <= load_data;
        end
    end

    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign busy      = busy_q;
    assign mem_data  = data_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: five instances with LATENCY 1..5 share one
// stimulus stream; a timeline model (accept cycle / response cycle per
// instance plus a word array) predicts every output on every cycle.
module tb_imem_responder;

    localparam int          NI  = 5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_read, load_en;
    logic [31:0] mem_addr, load_addr, load_data;

    logic [NI-1:0] rdy, err, bsy;
    logic [31:0]   dat [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        imem_responder #(.LATENCY(g + 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .mem_read  (mem_read),
            .mem_addr  (mem_addr),
            .mem_ready (rdy[g]),
            .mem_data  (dat[g]),
            .mem_err   (err[g]),
            .busy      (bsy[g]),
            .load_en   (load_en),
            .load_addr (load_addr),
            .load_data (load_data)
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mdl_mem [1024];
    int          acc  [NI];
    int          rsp  [NI];
    logic [9:0]  pidx [NI];
    logic        pmis [NI];
    logic [31:0] edat [NI];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict this edge from current inputs, then compare all outputs.
    task automatic step();
        int n;
        cyc++;
        n = cyc;
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                acc[k]  = -10;
                rsp[k]  = -10;
                edat[k] = 32'h0;
            end else begin
                if (mem_read && n >= rsp[k] + 2) begin
                    acc[k]  = n;
                    rsp[k]  = n + k;
                    pidx[k] = mem_addr[11:2];
                    pmis[k] = (mem_addr[1:0] != 2'b00);
                end
                if (n == rsp[k]) edat[k] = pmis[k] ? NOP : mdl_mem[pidx[k]];
            end
        end
        if (!reset && load_en) mdl_mem[load_addr[11:2]] = load_data;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("L%0d_ready", k + 1), 32'(rdy[k]), 32'(rsp[k] == n));
            chk($sformatf("L%0d_err", k + 1),   32'(err[k]), 32'(rsp[k] == n && pmis[k]));
            chk($sformatf("L%0d_busy", k + 1),  32'(bsy[k]), 32'(n >= acc[k] && n <= rsp[k]));
            chk($sformatf("L%0d_data", k + 1),  dat[k],      edat[k]);
        end
    endtask

    task automatic idle(input int n);
        mem_read = 1'b0;
        load_en  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pulses;
        int adj;
        logic prev;

        for (int k = 0; k < NI; k++) begin
            acc[k] = -10; rsp[k] = -10; pidx[k] = '0; pmis[k] = 1'b0; edat[k] = '0;
        end
        reset = 1'b1; mem_read = 1'b0; mem_addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;

        // Reset state
        step();
        step();
        chk("reset_data", dat[0], 32'h0);
        chk("reset_busy", 32'(bsy), 32'h0);
        reset = 1'b0;

        // Preload every word through the load port
        for (int i = 0; i < 1024; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i) << 2;
            case (i)
                1:       load_data = 32'h1234_5678;
                4:       load_data = 32'h0050_0093;
                5:       load_data = 32'h0BAD_F00D;
                8:       load_data = 32'hDEAD_BEEF;
                default: load_data = $urandom;
            endcase
            step();
        end
        idle(2);

        // LATENCY=1 basic read
        mem_read = 1'b1; mem_addr = 32'h10;
        step();
        chk("t1_ready", 32'(rdy[0]), 32'h1);
        chk("t1_data",  dat[0], 32'h0050_0093);
        chk("t1_err",   32'(err[0]), 32'h0);
        chk("t1_busy",  32'(bsy[0]), 32'h1);
        mem_read = 1'b0;
        step();
        chk("t1_busy_drop", 32'(bsy[0]), 32'h0);
        idle(6);

        // LATENCY=4 with mem_read toggling during WAIT
        mem_read = 1'b1; mem_addr = 32'h20;
        step();
        for (int i = 1; i <= 3; i++) begin
            mem_read = i[0];
            step();
        end
        chk("t2_ready", 32'(rdy[3]), 32'h1);
        chk("t2_data",  dat[3], 32'hDEAD_BEEF);
        mem_read = 1'b0;
        step();
        chk("t2_ready_off", 32'(rdy[3]), 32'h0);
        chk("t2_busy_off",  32'(bsy[3]), 32'h0);
        idle(6);

        // LATENCY=3 with mem_read held high
        mem_read = 1'b1; mem_addr = 32'h0;
        pulses = 0; adj = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            pulses += int'(rdy[2]);
            if (prev && rdy[2]) adj++;
            prev = rdy[2];
        end
        chk("t3_pulses", 32'(pulses), 32'd4);
        chk("t3_adjacent", 32'(adj), 32'd0);
        idle(7);

        // Misaligned then aligned
        mem_read = 1'b1; mem_addr = 32'h22;
        step();
        chk("t4_mis_ready", 32'(rdy[0]), 32'h1);
        chk("t4_mis_err",   32'(err[0]), 32'h1);
        chk("t4_mis_data",  dat[0], NOP);
        idle(6);
        mem_read = 1'b1; mem_addr = 32'h20;
        step();
        chk("t4_al_err",  32'(err[0]), 32'h0);
        chk("t4_al_data", dat[0], 32'hDEAD_BEEF);
        idle(6);

        // LATENCY=2 read-before-write on the edge entering RESP
        mem_read = 1'b1; mem_addr = 32'h14;
        step();
        mem_read = 1'b0;
        load_en = 1'b1; load_addr = 32'h14; load_data = 32'hCAFE_F00D;
        step();
        chk("t5_old_ready", 32'(rdy[1]), 32'h1);
        chk("t5_old_data",  dat[1], 32'h0BAD_F00D);
        idle(6);
        mem_read = 1'b1; mem_addr = 32'h14;
        step();
        mem_read = 1'b0;
        step();
        chk("t5_new_data", dat[1], 32'hCAFE_F00D);
        idle(6);

        // LATENCY=5 reset during WAIT
        mem_read = 1'b1; mem_addr = 32'h10;
        step();
        mem_read = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("t6_busy", 32'(bsy[4]), 32'h0);
        chk("t6_data", dat[4], 32'h0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            pulses += int'(rdy[4]);
        end
        chk("t6_no_pulse", 32'(pulses), 32'd0);
        // Reset and mem_read together: reset wins
        reset = 1'b1; mem_read = 1'b1; mem_addr = 32'h10;
        step();
        reset = 1'b0; mem_read = 1'b0;
        step();
        chk("t6_rst_wins", 32'(bsy), 32'h0);
        mem_read = 1'b1;
        step();
        mem_read = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t6_after_ready", 32'(rdy[4]), 32'h1);
        chk("t6_after_data",  dat[4], 32'h0050_0093);
        idle(6);

        // Address aliasing
        mem_read = 1'b1; mem_addr = 32'h1004;
        step();
        chk("t7_alias", dat[0], 32'h1234_5678);
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            mem_read = 1'($urandom_range(0, 1));
            mem_addr = $urandom;
            if ($urandom_range(0, 3) != 0) mem_addr[1:0] = 2'b00;
            load_en   = ($urandom_range(0, 4) == 0);
            load_addr = $urandom;
            load_data = $urandom;
            step();
        end
        reset = 1'b0;
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
